alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU interface: accepts an operation request over a valid/ready handshake and decodes it into the 4-bit ALU control code.
- Registers the operands onto the ALU inputs and waits a programmable settle time.
- Captures the ALU result and zero flag, and returns a response over a second valid/ready handshake, including the branch decision.
- Sits between decode and writeback/branch logic in the multi-cycle datapath.

---
 rtl/alu_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Initiator side of the ALU interface in the multi-cycle datapath. Accepts
// an operation request (valid/ready), decodes it into the 4-bit ALU control
// code, drives registered operands onto the ALU for EXEC_CYCLES cycles,
// then captures the ALU result/zero flag and returns a response
// (valid/ready) together with the branch decision.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake
//   req_alu_op, req_funct3,
//   req_funct7b5             operation encoding
//   req_rs1, req_rs2         operands
//   alu_a, alu_b,
//   ALU_Control              registered drive to the ALU
//   alu_result, alu_zero     ALU outputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_zero,
//   rsp_branch_taken,
//   rsp_illegal              captured response fields
//
// Optional feature: define ALU_ISSUE_STATS_EN to add the saturating 16-bit
// counters stat_ops and stat_illegal.
//
// State | meaning
// IDLE  | ready for a request
// EXEC  | operands held on the ALU, counting down the settle time
// RESP  | response presented, waiting for the consumer

module alu_issue_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  ALU_Control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_branch_taken,
    output logic        rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_illegal
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic [3:0] dec_ctrl;
    logic       dec_illegal, dec_branch, dec_bne;
    logic       op_illegal, op_branch, op_bne;
    logic       accept, capture, release_rsp;

    assign accept      = (state == IDLE) && req_valid;
    assign capture     = (state == EXEC) && (cnt == 4'd0);
    assign release_rsp = (state == RESP) && rsp_ready;

    always_comb begin
        dec_ctrl    = 4'b0010;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        case (req_alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: begin
                dec_ctrl   = 4'b0110;
                dec_branch = 1'b1;
                case (req_funct3)
                    3'b000:  dec_bne = 1'b0;
                    3'b001:  dec_bne = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (req_funct3)
                    3'b000:  dec_ctrl = req_funct7b5 ? 4'b0110 : 4'b0010;
                    3'b111:  dec_ctrl = 4'b0000;
                    3'b110:  dec_ctrl = 4'b0001;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_ctrl = 4'b1100;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = EXEC;
            EXEC:    if (capture)     state_nxt = RESP;
            RESP:    if (release_rsp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt              <= 4'd0;
            alu_a            <= 32'd0;
            alu_b            <= 32'd0;
            ALU_Control      <= 4'b0010;
            op_illegal       <= 1'b0;
            op_branch        <= 1'b0;
            op_bne           <= 1'b0;
            rsp_result       <= 32'd0;
            rsp_zero         <= 1'b0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= 4'(EXEC_CYCLES - 1);
                alu_a       <= req_rs1;
                alu_b       <= req_rs2;
                ALU_Control <= dec_ctrl;
                op_illegal  <= dec_illegal;
                op_branch   <= dec_branch;
                op_bne      <= dec_bne;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_result       <= alu_result;
                rsp_zero         <= alu_zero;
                // BEQ takes on zero, BNE on non-zero; illegal branches never take
                rsp_branch_taken <= op_branch && !op_illegal && (alu_zero ^ op_bne);
                rsp_illegal      <= op_illegal;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops     <= 16'd0;
            stat_illegal <= 16'd0;
        end else if (release_rsp) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (rsp_illegal && (stat_illegal != 16'hFFFF))
                stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int EXEC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_alu_op = 2'b00;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_funct7b5 = 1'b0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  ALU_Control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_branch_taken, rsp_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops, stat_illegal;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .alu_a(alu_a), .alu_b(alu_b), .ALU_Control(ALU_Control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_branch_taken(rsp_branch_taken), .rsp_illegal(rsp_illegal)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_ops(stat_ops), .stat_illegal(stat_illegal)
`endif
    );

    // Simple ALU sitting on the other side of the interface
    always_comb begin
        case (ALU_Control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = alu_a + alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction semantics) ----------------
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic b5);
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1100;
        if (op == 2'b10) begin
            if (f3 == 3'b111) return 4'b0000;
            if (f3 == 3'b110) return 4'b0001;
            if (f3 == 3'b000 && b5) return 4'b0110;
        end
        return 4'b0010;
    endfunction

    function automatic logic ref_illegal(input logic [1:0] op, input logic [2:0] f3);
        if (op == 2'b01) return !(f3 == 3'b000 || f3 == 3'b001);
        if (op == 2'b10) return !(f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110);
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [2:0] f3,
                                               input logic b5, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return ~(a | b);
            default: begin
                if (f3 == 3'b111) return a & b;
                if (f3 == 3'b110) return a | b;
                if (f3 == 3'b000 && b5) return a - b;
                return a + b;
            end
        endcase
    endfunction

    // model phase: 0 idle, 1 executing, 2 response pending
    int          m_phase = 0;
    int          m_left = 0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [3:0]  m_ctrl = 4'b0010;
    logic        m_zero = 0, m_taken = 0, m_ill = 0;
    int          m_ops = 0, m_ill_ops = 0;

    always begin
        @(negedge clk);
        if (rst) begin
            m_phase = 0; m_left = 0; m_a = 0; m_b = 0; m_res = 0;
            m_ctrl = 4'b0010; m_zero = 0; m_taken = 0; m_ill = 0;
            m_ops = 0; m_ill_ops = 0;
        end
        chk("req_ready", req_ready, m_phase == 0);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("ALU_Control", ALU_Control, m_ctrl);
        if (rst || m_phase == 2) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_branch_taken", rsp_branch_taken, m_taken);
            chk("rsp_illegal", rsp_illegal, m_ill);
        end
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_ops", stat_ops, m_ops);
        chk("stat_illegal", stat_illegal, m_ill_ops);
`endif
        @(posedge clk);
        if (!rst) begin
            if (m_phase == 0 && req_valid) begin
                m_a     = req_rs1;
                m_b     = req_rs2;
                m_ctrl  = ref_ctrl(req_alu_op, req_funct3, req_funct7b5);
                m_ill   = ref_illegal(req_alu_op, req_funct3);
                m_res   = ref_result(req_alu_op, req_funct3, req_funct7b5, req_rs1, req_rs2);
                m_zero  = (m_res == 0);
                m_taken = (req_alu_op == 2'b01) && !m_ill &&
                          ((req_funct3 == 3'b000) ? m_zero : !m_zero);
                m_left  = EXEC;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end else if (m_phase == 2 && rsp_ready) begin
                m_phase = 0;
                m_ops++;
                if (m_ill) m_ill_ops++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] r, output logic z, output logic t,
                         output logic il, output logic [3:0] c);
        bit ok = 0;
        int lat;
        r = 0; z = 0; t = 0; il = 0; c = 0;
        @(posedge clk); #1;
        req_alu_op = op; req_funct3 = f3; req_funct7b5 = b5;
        req_rs1 = a; req_rs2 = b; req_valid = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // inputs after acceptance must be ignored
        req_valid = 1'($urandom_range(0, 1));
        req_rs1 = $urandom; req_rs2 = $urandom;
        req_alu_op = 2'($urandom); req_funct3 = 3'($urandom);
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
        end
        chk("latency", lat, EXEC);
        if (lat == 40) begin
            req_valid = 1'b0;
            return;
        end
        r = rsp_result; z = rsp_zero; t = rsp_branch_taken; il = rsp_illegal; c = ALU_Control;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_result", rsp_result, r);
            chk("hold_taken", rsp_branch_taken, t);
            chk("hold_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        z, t, il;
        logic [3:0]  c;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", ALU_Control, 4'b0010);
        chk("reset_ready", req_ready, 1);

        issue(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 0, r, z, t, il, c);
        chk("add_ctrl", c, 4'b0010);
        chk("add_result", r, 32'd12);
        chk("add_zero", z, 0);

        issue(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, 5, r, z, t, il, c);
        chk("beq_ctrl", c, 4'b0110);
        chk("beq_zero", z, 1);
        chk("beq_taken", t, 1);

        issue(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234, 0, r, z, t, il, c);
        chk("bne_taken", t, 0);

        issue(2'b10, 3'b100, 1'b0, 32'd3, 32'd4, 1, r, z, t, il, c);
        chk("illegal_ctrl", c, 4'b0010);
        chk("illegal_flag", il, 1);
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_illegal_one", stat_illegal, 16'd1);
`endif

        issue(2'b11, 3'b000, 1'b0, 32'd0, 32'd0, 0, r, z, t, il, c);
        chk("nor_result", r, 32'hFFFF_FFFF);
        chk("nor_zero", z, 0);

        issue(2'b10, 3'b000, 1'b1, 32'd0, 32'd1, 0, r, z, t, il, c);
        chk("sub_wrap", r, 32'hFFFF_FFFF);

        // reset in the middle of execution
        @(posedge clk); #1;
        req_alu_op = 2'b11; req_funct3 = 3'b000; req_rs1 = 32'h55; req_rs2 = 32'h0F;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ctrl", ALU_Control, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < EXEC + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        chk("mid_rst_no_rsp", lat, 0);
        rsp_ready = 1'b0;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            issue(2'($urandom), 3'($urandom), 1'($urandom), a, b,
                  $urandom_range(0, 3), r, z, t, il, c);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
